hpel_row_filter: RTL and testbench
==================================

HPEL_ROW_FILTER -- requirements
Module: hpel_row_filter

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset; in_valid in 1; in_ready out 1; in_pix in 8 unsigned pixel; in_sol in 1 first pixel of row; in_eol in 1 last pixel of row; mode in 1 (0=H.264 6-tap, 1=AVS 4-tap); out_valid out 1; out_ready in 1; out_pix out 8 half-pel sample; out_eol out 1 last sample of row.
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 SHALL have no parameters; line length is implied by in_sol/in_eol, with no maximum.

Function
REQ-004 SHALL, for a row p0..pN-1, emit N-1 samples h0..hN-2, where h_i lies between p_i and p_i+1, with edge replication (p_k=p0 for k<0; p_k=pN-1 for k>N-1).
REQ-005 SHALL hold a 6-entry window A..F = p_i-2..p_i+3; H.264: h=clip255((A+F)-5(B+E)+20(C+D)+16)>>>5; AVS: h=clip255(5(C+D)-(B+E)+4)>>>3.
REQ-006 SHALL use signed intermediates of at least 15 bits, an arithmetic shift (floor) and a clip to 0..255.
REQ-007 SHALL latch mode on in_sol acceptance, so mode changes mid-row have no effect.
REQ-008 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-009 IDLE: in_ready=1; beats without in_sol are dropped; an in_sol beat loads all 6 entries with in_pix, clears the shift count and goes to RUN, or to FLUSH if in_eol is also set.
REQ-010 RUN: each accepted beat shifts in_pix into F and increments the shift count; an in_eol beat goes to FLUSH.
REQ-011 FLUSH: in_ready=0; exactly 2 shifts of replicated pN-1 (F), each taken when the output register is free; after the 2nd shift goes to IDLE.
REQ-012 Every shift with resulting count>=3 SHALL load out_pix from the post-shift window and set out_valid on the next edge (1-cycle latency); a row with N=1 produces no output.
REQ-013 out_eol SHALL be set with the sample produced by the 2nd FLUSH shift, and only when count>=3.
REQ-014 out_valid/out_pix/out_eol SHALL hold while out_valid=1 and out_ready=0; a transfer occurs when both are high.
REQ-015 in_ready SHALL be (state IDLE or RUN) and (out_valid=0 or out_ready=1); no shift occurs while stalled.
REQ-016 An in_sol beat accepted in RUN SHALL abort the current row (no flush, no out_eol) and restart as in REQ-009; a pending output still completes.
REQ-017 Back-to-back rows: an in_sol beat SHALL be accepted on the cycle after FLUSH exits.

Reset
REQ-018 On rst SHALL set: state IDLE; out_valid=0; out_pix=0; out_eol=0; window=0; count=0; latched mode=0.
REQ-019 rst mid-row SHALL discard the row and any held output, and SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-020 Macro HPEL_AVS_EN: when defined, mode selects H.264/AVS per REQ-005; when undefined, the mode port is present but ignored, only H.264 is computed, and no AVS datapath is built.

Verification
REQ-021 Flat row N=8, all 100, H.264 -> seven outputs of 100; out_eol on the 7th only.
REQ-022 Row 0,0,0,255,255,255, H.264 -> 8,0,128,255,247, out_eol on 247; same row with AVS (HPEL_AVS_EN) -> h2=128.
REQ-023 N=2 row 10,20, H.264 -> single output 15 with out_eol; N=1 row -> no output, in_ready=1 two FLUSH cycles later.
REQ-024 out_ready held low 5 cycles mid-row -> in_ready low, out_pix stable, full sample sequence unchanged versus an unstalled run.
REQ-025 in_sol injected in RUN after 3 pixels -> no out_eol for the aborted row, new row correct; rst mid-row -> all outputs 0, state IDLE the next cycle.

Source files
------------

// File: rtl/hpel_row_filter.sv
// Half-pel row interpolator: streams one pixel row through a 6-entry window and emits N-1 samples between neighbours.
// Optional macro HPEL_AVS_EN adds the AVS 4-tap filter, selected by mode latched at row start.

module hpel_row_filter (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pix,
  input  logic       in_sol,
  input  logic       in_eol,
  input  logic       mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pix,
  output logic       out_eol
);

  localparam int unsigned PW   = 8;
  localparam int unsigned TAPS = 6;
  localparam int unsigned IW   = 16;
  localparam int unsigned CW   = 2;

  localparam logic [CW-1:0]        CNT_OUT = CW'(3);
  localparam logic signed [IW-1:0] K4      = IW'(4);
  localparam logic signed [IW-1:0] K5      = IW'(5);
  localparam logic signed [IW-1:0] K16     = IW'(16);
  localparam logic signed [IW-1:0] K20     = IW'(20);
  localparam logic signed [IW-1:0] PMAX    = IW'(255);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [TAPS-1:0][PW-1:0] win_q, win_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    fl_q, fl_d;

  logic          out_free_c;
  logic          accept_c;
  logic          load_c;
  logic          shift_c;
  logic          last_c;
  logic          emit_c;
  logic [PW-1:0] shift_pix_c;
  logic [PW-1:0] res_c;

  logic signed [IW-1:0] ta_c, tb_c, tc_c, td_c, te_c, tf_c;
  logic signed [IW-1:0] sum_h_c, sh_h_c;

`ifdef HPEL_AVS_EN
  logic                 mode_q, mode_d;
  logic signed [IW-1:0] sum_a_c, sh_a_c;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  function automatic logic [PW-1:0] clip8(input logic signed [IW-1:0] v);
    if (v[IW-1])
      clip8 = '0;
    else if (v > PMAX)
      clip8 = '1;
    else
      clip8 = v[PW-1:0];
  endfunction

  assign out_free_c = !out_valid || out_ready;
  assign in_ready   = (state_q != FLUSH) && out_free_c;
  assign accept_c   = in_valid && in_ready;
  assign emit_c     = shift_c && (cnt_d == CNT_OUT);

  // Next-state, window shift and saturating shift count
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    fl_d        = fl_q;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    last_c      = 1'b0;
    shift_pix_c = in_pix;
`ifdef HPEL_AVS_EN
    mode_d      = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept_c && in_sol) begin
          load_c  = 1'b1;
          state_d = in_eol ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept_c) begin
          if (in_sol) load_c = 1'b1;
          else        shift_c = 1'b1;
          if (in_eol) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free_c) begin
          shift_c     = 1'b1;
          shift_pix_c = win_q[TAPS-1];
          last_c      = fl_q;
          fl_d        = !fl_q;
          if (fl_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      win_d = {TAPS{in_pix}};
      cnt_d = '0;
      fl_d  = 1'b0;
`ifdef HPEL_AVS_EN
      mode_d = mode;
`endif
    end
    if (shift_c) begin
      win_d = {shift_pix_c, win_q[TAPS-1:1]};
      cnt_d = (cnt_q == CNT_OUT) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Filter taps are taken from the post-shift window
  assign ta_c = $signed(IW'(win_d[0]));
  assign tb_c = $signed(IW'(win_d[1]));
  assign tc_c = $signed(IW'(win_d[2]));
  assign td_c = $signed(IW'(win_d[3]));
  assign te_c = $signed(IW'(win_d[4]));
  assign tf_c = $signed(IW'(win_d[5]));

  assign sum_h_c = (ta_c + tf_c) - K5 * (tb_c + te_c) + K20 * (tc_c + td_c) + K16;
  assign sh_h_c  = sum_h_c >>> 5;

`ifdef HPEL_AVS_EN
  assign sum_a_c = K5 * (tc_c + td_c) - (tb_c + te_c) + K4;
  assign sh_a_c  = sum_a_c >>> 3;
  assign res_c   = mode_q ? clip8(sh_a_c) : clip8(sh_h_c);
`else
  assign res_c   = clip8(sh_h_c);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      fl_q    <= 1'b0;
`ifdef HPEL_AVS_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
`ifdef HPEL_AVS_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Output register holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_eol   <= 1'b0;
    end else if (out_free_c) begin
      out_valid <= emit_c;
      out_eol   <= emit_c && last_c;
      if (emit_c) out_pix <= res_c;
    end
  end

endmodule

// File: tb/tb_hpel_row_filter.sv
// Directed bench for hpel_row_filter: a row-level reference model scores every transfer, literal rows pin the model.

module tb_hpel_row_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
  logic       in_sol;
  logic       in_eol;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pix;
  logic       out_eol;

  int checks   = 0;
  int failures = 0;
  int exp_pix[$];
  int exp_eol[$];
  int log_pix[$];
  int log_eol[$];
  int stall_cycles = 0;
  bit prev_stall   = 1'b0;
  int prev_pix;
  int prev_eol;
  int ep;
  int ee;

  always #5 clk = ~clk;

  hpel_row_filter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sol    (in_sol),
    .in_eol    (in_eol),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_eol   (out_eol)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Half-pel sample i of row r (length n) with edge replication
  function automatic int hval(input int r[$], input int n, input int i, input bit m);
    int p[6];
    int idx;
    int v;
    for (int k = 0; k < 6; k++) begin
      idx = i - 2 + k;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      p[k] = r[idx];
    end
    if (m) v = (5 * (p[2] + p[3]) - (p[1] + p[4]) + 4) >>> 3;
    else   v = ((p[0] + p[5]) - 5 * (p[1] + p[4]) + 20 * (p[2] + p[3]) + 16) >>> 5;
    return clip(v);
  endfunction

  // One input beat; starts and ends just after a rising edge
  task automatic beat(input int p, input bit sol, input bit eol, input bit m, output int waited);
    bit acc;
    in_valid = 1'b1;
    in_pix   = 8'(p);
    in_sol   = sol;
    in_eol   = eol;
    mode     = m;
    waited   = 0;
    acc      = 1'b0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("beat_timeout", int'(in_ready), 1);
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
  endtask

  // Complete rows get flush samples; aborted rows only produce samples fully inside them
  task automatic send_row(input int r[$], input bit m, input bit complete, output int first_wait);
    int n;
    int w;
    bit em;
    n  = r.size();
    em = 1'b0;
`ifdef HPEL_AVS_EN
    em = m;
`endif
    if (complete) begin
      for (int i = 0; i <= n - 2; i++) begin
        exp_pix.push_back(hval(r, n, i, em));
        exp_eol.push_back((i == n - 2) ? 1 : 0);
      end
    end else begin
      for (int i = 0; i <= n - 4; i++) begin
        exp_pix.push_back(hval(r, n, i, em));
        exp_eol.push_back(0);
      end
    end
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      beat(r[i], i == 0, complete && (i == n - 1), (i == 0) ? m : !m, w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_pix.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", exp_pix.size(), 0);
  endtask

  task automatic chk_log(input string name, input int start, input int vals[$]);
    int n;
    n = vals.size();
    chk({name, "_count"}, log_pix.size() - start, n);
    if (log_pix.size() - start >= n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_pix"}, log_pix[start + i], vals[i]);
        chk({name, "_eol"}, log_eol[start + i], (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  // Scoreboard: every transfer against the model, plus hold/backpressure while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_pix", int'(out_pix), prev_pix);
        chk("stall_eol", int'(out_eol), prev_eol);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", int'(in_ready), 0);
        stall_cycles++;
      end
      if (out_valid && out_ready) begin
        log_pix.push_back(int'(out_pix));
        log_eol.push_back(int'(out_eol));
        if (exp_pix.size() == 0) begin
          chk("unexpected_out", int'(out_valid), 0);
        end else begin
          ep = exp_pix.pop_front();
          ee = exp_eol.pop_front();
          chk("out_pix", int'(out_pix), ep);
          chk("out_eol", int'(out_eol), ee);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = int'(out_pix);
      prev_eol   = int'(out_eol);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int row[$];
    int lit[$];
    int w;
    int s;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sol    = 1'b0;
    in_eol    = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_out_eol", int'(out_eol), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Flat row
    s   = log_pix.size();
    row = {100, 100, 100, 100, 100, 100, 100, 100};
    send_row(row, 1'b0, 1'b1, w);
    drain();
    lit = {100, 100, 100, 100, 100, 100, 100};
    chk_log("flat", s, lit);

    // Step edge exercising floor shift and both clip limits
    s   = log_pix.size();
    row = {0, 0, 0, 255, 255, 255};
    send_row(row, 1'b0, 1'b1, w);
    drain();
    lit = {8, 0, 128, 255, 247};
    chk_log("step", s, lit);

`ifdef HPEL_AVS_EN
    s = log_pix.size();
    send_row(row, 1'b1, 1'b1, w);
    drain();
    chk("avs_count", log_pix.size() - s, 5);
    if (log_pix.size() - s >= 3) chk("avs_h2", log_pix[s + 2], 128);
`endif

    // Two-pixel row
    s   = log_pix.size();
    row = {10, 20};
    send_row(row, 1'b0, 1'b1, w);
    drain();
    lit = {15};
    chk_log("n2", s, lit);

    // Single-pixel row: no output, two flush cycles
    s   = log_pix.size();
    row = {77};
    send_row(row, 1'b0, 1'b1, w);
    chk("n1_flush_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("n1_ready", int'(in_ready), 1);
    drain();
    chk("n1_no_out", log_pix.size() - s, 0);

    // Back-to-back rows with mode toggled mid-row
    row = {12, 200, 33, 90, 150, 7, 64};
    send_row(row, 1'b1, 1'b1, w);
    row = {255, 0, 255, 0, 255, 0, 128, 128, 9};
    send_row(row, 1'b0, 1'b1, w);
    chk("b2b_gap", w, 3);
    drain();

    // Consumer stall mid-row
    row = {10, 50, 90, 130, 170, 210, 250, 200, 150, 100, 50, 0};
    stall_cycles = 0;
    fork
      send_row(row, 1'b0, 1'b1, w);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles", stall_cycles, 5);

    // Abort after 3 pixels, then after 5 pixels
    row = {5, 6, 7};
    send_row(row, 1'b1, 1'b0, w);
    s   = log_pix.size();
    row = {30, 40, 50, 60, 70};
    send_row(row, 1'b0, 1'b1, w);
    drain();
    lit = {34, 45, 55, 66};
    chk_log("abort3", s, lit);
    row = {1, 2, 3, 200, 250};
    send_row(row, 1'b0, 1'b0, w);
    row = {30, 40, 50, 60, 70};
    send_row(row, 1'b0, 1'b1, w);
    drain();

    // Reset mid-row wins over a concurrent start-of-row beat
    row = {90, 80, 70, 60, 50};
    send_row(row, 1'b0, 1'b0, w);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sol   = 1'b1;
    in_eol   = 1'b1;
    in_pix   = 8'd99;
    exp_pix.delete();
    exp_eol.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pix", int'(out_pix), 0);
    chk("midrst_out_eol", int'(out_eol), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;

    // Beat without in_sol in IDLE is dropped
    beat(200, 1'b0, 1'b1, 1'b0, w);
    chk("drop_in_ready", int'(in_ready), 1);
    s   = log_pix.size();
    row = {15, 25, 35, 45};
    send_row(row, 1'b0, 1'b1, w);
    drain();
    chk("post_rst_count", log_pix.size() - s, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
